// File: rtl/multiword_add_sequencer.sv
// Serial WORDS*32-bit add/subtract over one shared 32-bit CLA slice.
// Define SEQ_OVERFLOW_EN to add the signed-overflow output.
module carry_lookahead_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  function automatic logic [3:0] cla4(
    input logic [3:0] gg,
    input logic [3:0] pp,
    input logic       ci
  );
    logic [3:0] co;
    co[0] = gg[0] | (pp[0] & ci);
    co[1] = gg[1] | (pp[1] & gg[0])
          | (&pp[1:0] & ci);
    co[2] = gg[2] | (pp[2] & gg[1])
          | (&pp[2:1] & gg[0])
          | (&pp[2:0] & ci);
    co[3] = gg[3] | (pp[3] & gg[2])
          | (&pp[3:2] & gg[1])
          | (&pp[3:1] & gg[0])
          | (&pp[3:0] & ci);
    return co;
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups, group carries chained
  always_comb begin
    c    = '0;
    c[0] = c_in;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1 +: 4] = cla4(g[4*k +: 4],
                           p[4*k +: 4],
                           c[4*k]);
    end
  end

  assign s     = p ^ c[31:0];
  assign c_out = c[32];
endmodule

module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sub,
  input  logic [WORDS*32-1:0] a,
  input  logic [WORDS*32-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [WORDS*32-1:0] result,
  output logic               c_out
`ifdef SEQ_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);
  localparam int W  = WORDS * 32;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST =
    IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [31:0]   a_sl;
  logic [31:0]   b_sl;
  logic [31:0]   s_sl;
  logic          co_sl;

  assign a_sl = a_q[idx*32 +: 32];
  assign b_sl = b_q[idx*32 +: 32];

  carry_lookahead_adder_32bit u_cla (
    .a    (a_sl),
    .b    (b_sl),
    .c_in (carry),
    .s    (s_sl),
    .c_out(co_sl)
  );

`ifdef SEQ_OVERFLOW_EN
  // carry into the top bit recovered from its sum bit
  logic ov_sl;
  assign ov_sl = s_sl[31] ^ a_sl[31]
               ^ b_sl[31] ^ co_sl;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
`ifdef SEQ_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= sub ? ~b : b;
            carry  <= sub;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result[idx*32 +: 32] <= s_sl;
          carry <= co_sl;
          if (idx == LAST) begin
            c_out <= co_sl;
`ifdef SEQ_OVERFLOW_EN
            overflow <= ov_sl;
`endif
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer, WORDS=4.
// Stimulus pushes expectations; a done-driven monitor checks them.
module tb_multiword_add_sequencer;
  localparam int WORDS = 4;
  localparam int W = WORDS * 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
`ifdef SEQ_OVERFLOW_EN
  logic         overflow;
`endif

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .c_out (c_out)
`ifdef SEQ_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] ONE  = 1;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("c_out", W'(c_out), W'(e.co));
`ifdef SEQ_OVERFLOW_EN
        chk("overflow", W'(overflow), W'(e.ov));
`endif
      end
    end
  end

  // Called at a negedge; ign>0 pulses a stray start n cycles in
  task automatic run_op(input logic s,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic [W-1:0] er,
                        input logic ec,
                        input logic eo,
                        input int ign);
    int n;
    sb.push_back('{er, ec, eo});
    sub = s; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~x; b = ~y; sub = ~s;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1)
        chk("busy_run", W'(busy), ONE);
      if (done) break;
      start = (ign != 0 && n == ign);
    end
    start = 1'b0;
    chk("latency", W'(n), W'(WORDS + 1));
    chk("busy_done", W'(busy), ONE);
    @(negedge clk);
    chk("idle_after", W'({busy, done}), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0;
    a = '0; b = '0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("reset_state",
          W'({busy, done, c_out}) | result, '0);
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_state",
          W'({busy, done, c_out}) | result, '0);
    end

    // T2: carry ripples into slice 1
    run_op(1'b0, ONE, W'(32'hffff_ffff),
           W'(1) << 32, 1'b0, 1'b0, 0);
    // T3: all ones plus all ones
    run_op(1'b0, ONES, ONES,
           ONES - 1, 1'b1, 1'b0, 0);
    // T4: 5 - 7 borrows
    run_op(1'b1, W'(5), W'(7),
           ONES - 1, 1'b0, 1'b0, 0);
    // T5: signed overflow, stray start ignored
    run_op(1'b0, ONES >> 1, ONE,
           ONE << (W - 1), 1'b0, 1'b1, 2);
    run_op(1'b1, W'(10), W'(3),
           W'(7), 1'b1, 1'b0, 0);
    run_op(1'b1, ONE << 64, ONE,
           (ONE << 64) - 1, 1'b1, 1'b0, 0);
    run_op(1'b0, ONES, ONE,
           '0, 1'b1, 1'b0, 0);
    run_op(1'b1, ONE << (W - 1), ONE,
           ONES >> 1, 1'b1, 1'b1, 0);

    // T6: reset mid-operation
    sub = 1'b0; a = ONES; b = ONES; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(busy), '0);
    chk("abort_result", result, '0);
    reset = 1'b0;
    run_op(1'b0, W'(32'h1234), W'(32'h1111),
           W'(32'h2345), 1'b0, 1'b0, 0);

    repeat (8) @(negedge clk);
    chk("sb_empty", W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
